// File: rtl/data_mem_pkg.sv
// Shared types and constants for the pipelined data memory.
//   mem_state_e      : controller state (clear sequence / ready for requests)
//   MAX_READ_LATENCY : deepest supported read pipeline
//   byte_merge()     : reference masked-write semantics (byte i of the result
//                      comes from new_word when byteen[i]=1, else from old_word)
package data_mem_pkg;

  typedef enum logic {
    MS_CLEAR = 1'b0,
    MS_READY = 1'b1
  } mem_state_e;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_DATA_WIDTH   = 256;
  localparam int MAX_BYTES        = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0]      byteen
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (byteen[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_rd_pipe.sv
// Valid/data delay line for read responses.
//   clk       : clock
//   srst      : synchronous active-high clear of all valid bits
//   in_valid  : stage input valid
//   in_data   : stage input data [WIDTH]
//   out_valid : valid delayed by DEPTH cycles
//   out_data  : data delayed by DEPTH cycles
// DEPTH=0 makes the block a pair of wires.
module data_mem_rd_pipe #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    // Clock and clear have nothing to act on in the zero-depth case.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, srst};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end

    // Only the valid bits need clearing; stale data is never qualified.
    always_ff @(posedge clk) begin
      if (srst) valid_q <= '0;
      else      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/data_mem_pipelined.sv
// Single-port data memory with valid/ready requests, byte-enable writes,
// a fixed read latency and an optional zeroing sequence after reset.
//   CLK        : clock, all logic on posedge
//   Reset      : synchronous active-high reset
//   ReqValid   : request present
//   ReqReady   : request can be accepted this cycle (state only)
//   ReqWrite   : 1 = write, 0 = read
//   ReqAddr    : word address [ADDR_WIDTH]
//   ReqData    : write data [DATA_WIDTH]
//   ReqByteEn  : per-byte write enable [DATA_WIDTH/8]
//   RespValid  : one-cycle read response pulse
//   RespData   : read data, held between responses, zero after reset
//   Busy       : clear sequence running
module data_mem_pipelined
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [ADDR_WIDTH-1:0]   ReqAddr,
  input  logic [DATA_WIDTH-1:0]   ReqData,
  input  logic [DATA_WIDTH/8-1:0] ReqByteEn,
  output logic                    RespValid,
  output logic [DATA_WIDTH-1:0]   RespData,
  output logic                    Busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("data_mem_pipelined: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("data_mem_pipelined: DATA_WIDTH must be a non-zero multiple of 8");
  end

  // ---------------- controller FSM ----------------
  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clearing;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= CLEAR_ON_RESET ? MS_CLEAR : MS_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      MS_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = MS_READY;
      end
      default: ;
    endcase
  end

  always_comb begin
    ReqReady = 1'b0;
    Busy     = 1'b0;
    clearing = 1'b0;
    case (state_q)
      MS_CLEAR: begin
        Busy     = 1'b1;
        clearing = 1'b1;
      end
      MS_READY: ReqReady = 1'b1;
      default: ;
    endcase
  end

  // ---------------- accept logic ----------------
  // A request coinciding with Reset is discarded so that nothing started in
  // the reset cycle can surface afterwards.
  logic accept, wr_accept, rd_accept;
  assign accept    = ReqValid && ReqReady && !Reset;
  assign wr_accept = accept && ReqWrite;
  assign rd_accept = accept && !ReqWrite;

  // ---------------- storage array ----------------
  logic [NUM_BYTES-1:0]  mem_be;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // The clear sequence and request writes share the single write port;
  // they are mutually exclusive because ReqReady is low while clearing.
  always_comb begin
    if (clearing) begin
      mem_be    = Reset ? '0 : '1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_be    = wr_accept ? ReqByteEn : '0;
      mem_waddr = ReqAddr;
      mem_wdata = ReqData;
    end
  end

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mem_be[i]) mem_array[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
  end

  // Registered read port: this register is the first latency cycle.
  // Kept as a plain array read so the array maps onto block RAM.
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign rd_valid_d = rd_accept;

  always_ff @(posedge CLK) begin
    if (Reset) rd_valid_q <= 1'b0;
    else       rd_valid_q <= rd_valid_d;
  end

  always_ff @(posedge CLK) begin
    if (rd_accept) rd_data_q <= mem_array[ReqAddr];
  end

  // ---------------- remaining latency ----------------
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  data_mem_rd_pipe #(
    .DEPTH (READ_LATENCY - 1),
    .WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (CLK),
    .srst      (Reset),
    .in_valid  (rd_valid_q),
    .in_data   (rd_data_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // RespData shows the live pipeline output on a response and the last
  // response otherwise, without adding a cycle of latency.
  logic [DATA_WIDTH-1:0] resp_hold_q, resp_hold_d;

  assign resp_hold_d = pipe_valid ? pipe_data : resp_hold_q;

  always_ff @(posedge CLK) begin
    if (Reset) resp_hold_q <= '0;
    else       resp_hold_q <= resp_hold_d;
  end

  assign RespValid = pipe_valid;
  assign RespData  = pipe_valid ? pipe_data : resp_hold_q;

endmodule

// File: doc/data_mem_pipelined.md
# data_mem_pipelined

Parametrised single-port data memory with a valid/ready request interface, byte-enable writes, configurable fixed read latency and an optional hardware clear sequence after reset. It sits between the core's load/store stage and the storage array. It replaces the fixed 8-bit, 256-entry, one-cycle memory where wider data, deeper arrays or deeper read pipelines are needed.

## Interface
- ADDR_WIDTH, 8: address bits; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: word width; must be a multiple of 8.
- READ_LATENCY, 1: cycles from read accept to RespValid; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents retained across reset.
- CLK  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request this cycle.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_WIDTH  word address.
- ReqData  in  DATA_WIDTH  write data.
- ReqByteEn  in  DATA_WIDTH/8  per-byte write enable; ignored on reads.
- RespValid  out  1  one-cycle pulse: RespData holds read data.
- RespData  out  DATA_WIDTH  read data; holds its value between responses.
- Busy  out  1  clear sequence in progress.

## Operation
- Two-state FSM:
  - MS_CLEAR: clear counter walks 0..2**ADDR_WIDTH-1, writing all-zero to one word per cycle. ReqReady=0, Busy=1. After the last address, go to MS_READY.
  - MS_READY: ReqReady=1, Busy=0. Stays in MS_READY until Reset.
- Reset sampled high:
  - Next state is MS_CLEAR if CLEAR_ON_RESET=1, else MS_READY.
  - Clear counter := 0.
  - All read-pipeline valid bits cleared.
- Output values in the cycle after Reset:
  - ReqReady=0 (CLEAR) or 1 (no clear).
  - Busy=1 or 0 to match.
  - RespValid=0, RespData=0.
- Accept: ReqValid && ReqReady. Exactly one request per cycle; back-to-back accepts are allowed every cycle.
- Write accept:
  - For each byte i with ReqByteEn[i]=1, mem[ReqAddr] byte i := ReqData byte i at the end of the accept cycle.
  - Bytes with ReqByteEn[i]=0 are unchanged.
  - Writes produce no response.
- Read accept: the array is read at the end of the accept cycle, and the value travels down a READ_LATENCY-1 stage register pipeline with a valid bit.
- Read-after-write ordering: a read accepted any cycle after a write to the same address returns the written data. No forwarding is needed because there is one port and one request per cycle.
- No response backpressure: the consumer must take RespValid when it is asserted.
- ReqValid while ReqReady=0: ignored, nothing is recorded. The requester holds the request until accepted.
- Reset mid-operation:
  - In-flight reads are dropped; RespValid=0 from the next cycle.
  - A clear in progress restarts at address 0.
- Out-of-range READ_LATENCY or DATA_WIDTH is rejected by an elaboration-time check.

## Timing
- Read latency: accept in cycle N gives RespValid=1 and valid RespData in cycle N+READ_LATENCY.
- Throughput: one read per cycle; all responses return in order.
- Write visibility: a write in cycle N is visible to a read accepted in cycle N+1.
- Clear duration: 2**ADDR_WIDTH cycles. The first accept is possible in cycle 2**ADDR_WIDTH+1 after the reset cycle.
- ReqReady depends only on FSM state, never combinationally on ReqValid.

## Structure
- Package data_mem_pkg:
  - enum mem_state_e {MS_CLEAR, MS_READY}.
  - MAX_READ_LATENCY=4.
  - Function byte_merge(old, new, byteen) for the masked write.
- Sub-module data_mem_rd_pipe: parametrised valid/data delay line of depth READ_LATENCY-1, with synchronous clear of the valid bits. Its depth is 0 for READ_LATENCY=1, where it degenerates to wires.
- The array, FSM, clear counter and accept logic live in the top module.

## Test plan
- Clear after reset (ADDR_WIDTH=4, CLEAR_ON_RESET=1):
  - Stimulus: preload word 5 = 0xA5, pulse Reset.
  - Required: Busy=1 and ReqReady=0 for 16 cycles, then ReqReady=1; a read of address 5 returns 0x00.
- Retention (CLEAR_ON_RESET=0):
  - Stimulus: write 0x3C to address 7, pulse Reset, read address 7.
  - Required: ReqReady=1 the cycle after Reset; the read returns 0x3C.
- Byte enables (DATA_WIDTH=32):
  - Stimulus: write 0x11223344 with ByteEn=1111 to address 2, then 0xAABBCCDD with ByteEn=0101, then read address 2.
  - Required: RespData=0x11BB33DD.
- Latency and streaming (READ_LATENCY=3):
  - Stimulus: reads of addresses 0,1,2,3 accepted in cycles 10..13.
  - Required: RespValid in cycles 13..16 with matching data in order, then RespValid=0.
- Write-then-read:
  - Stimulus: write 0x5A to address 9 in cycle N, read address 9 in cycle N+1.
  - Required: response 0x5A.
- Reset with reads in flight (READ_LATENCY=4):
  - Stimulus: two reads outstanding, assert Reset for one cycle.
  - Required: no RespValid afterwards; RespData=0.
